// File: rtl/router_out_arbiter_pkg.sv
// Shared types for the router output arbiter: flit type encoding, arbiter
// states and small flit-classification helpers.
package router_pkg;

  localparam int FlitTypeBits = 2;

  typedef enum logic [1:0] {
    BODY     = 2'b00,
    TAIL     = 2'b01,
    HEAD     = 2'b10,
    HEADTAIL = 2'b11
  } flit_type_t;

  typedef enum logic {
    IDLE = 1'b0,
    BUSY = 1'b1
  } arb_state_t;

  // A header opens a packet; a tail (or single-flit packet) closes it.
  function automatic logic is_header(flit_type_t t);
    return (t == HEAD) || (t == HEADTAIL);
  endfunction

  function automatic logic is_last(flit_type_t t);
    return (t == TAIL) || (t == HEADTAIL);
  endfunction

endpackage

// File: rtl/router_out_arbiter_if.sv
// Bundle between the input FIFOs, the output link and the output arbiter.
// master = arbiter side, slave = FIFOs/link side.
interface router_out_if #(
  parameter int NumInputs = 5,
  parameter int Width     = 8
);
  logic [NumInputs-1:0]            in_empty;
  logic [NumInputs-1:0][Width-1:0] in_data;
  logic [NumInputs-1:0]            in_rdreq;
  logic                            out_full;
  logic                            out_valid;
  logic [Width-1:0]                out_data;
  logic [NumInputs-1:0]            grant;
  logic                            err;

  modport master (
    input  in_empty, in_data, out_full,
    output in_rdreq, out_valid, out_data, grant, err
  );

  modport slave (
    output in_empty, in_data, out_full,
    input  in_rdreq, out_valid, out_data, grant, err
  );
endinterface

// File: rtl/router_out_arbiter_rr.sv
// Combinational rotating-priority selector: one-hot grant to the first
// requester at or after ptr, wrapping modulo N.
module router_rr_arbiter #(
  parameter int N    = 5,
  parameter int PtrW = $clog2(N)
) (
  input  logic [N-1:0]    req,
  input  logic [PtrW-1:0] ptr,
  output logic [N-1:0]    gnt,
  output logic            valid
);

  logic [PtrW-1:0] idx;

  always_comb begin
    gnt   = '0;
    valid = 1'b0;
    idx   = '0;
    for (int k = 0; k < N; k++) begin
      idx = PtrW'((int'(ptr) + k) % N);
      if (!valid && req[idx]) begin
        gnt[idx] = 1'b1;
        valid    = 1'b1;
      end
    end
  end

endmodule

// File: rtl/router_out_arbiter.sv
// Wormhole output-port arbiter: round-robin over header flits, then locked to
// the owner until its tail passes. Watchdog enabled by ROUTER_ARB_WATCHDOG_EN.
module router_out_arbiter
  import router_pkg::*;
#(
  parameter int NumInputs     = 5,
  parameter int Width         = 8,
  parameter int TimeoutCycles = 64
) (
  input  logic        clk,
  input  logic        rst,
  router_out_if.master bus
);

  localparam int FlitTypeMsb = Width - 1;
  localparam int PtrW        = $clog2(NumInputs);

  if (NumInputs < 2 || Width < 3 || TimeoutCycles < 1) begin : g_bad_params
    $error("router_out_arbiter: illegal parameter set");
  end

  arb_state_t           state_q, state_d;
  logic [NumInputs-1:0] grant_q, grant_d;
  logic [PtrW-1:0]      owner_q, owner_d;
  logic [PtrW-1:0]      ptr_q, ptr_d;
  logic                 err_q, err_d;
  logic                 first_q, first_d;

  logic [NumInputs-1:0] cand, bad_head, arb_gnt;
  logic                 arb_valid;
  logic [PtrW-1:0]      arb_idx, owner_next;
  logic [Width-1:0]     owner_flit;
  flit_type_t           owner_type, head_type;
  logic                 fwd, timeout;

  always_comb begin
    cand      = '0;
    bad_head  = '0;
    head_type = BODY;
    for (int i = 0; i < NumInputs; i++) begin
      head_type   = flit_type_t'(bus.in_data[i][FlitTypeMsb -: FlitTypeBits]);
      cand[i]     = !bus.in_empty[i] && is_header(head_type);
      bad_head[i] = !bus.in_empty[i] && !is_header(head_type);
    end
  end

  router_rr_arbiter #(
    .N    (NumInputs),
    .PtrW (PtrW)
  ) u_rr (
    .req   (cand),
    .ptr   (ptr_q),
    .gnt   (arb_gnt),
    .valid (arb_valid)
  );

  always_comb begin
    arb_idx = '0;
    for (int i = 0; i < NumInputs; i++) begin
      if (arb_gnt[i]) arb_idx = PtrW'(i);
    end
  end

  assign owner_flit = bus.in_data[owner_q];
  assign owner_type = flit_type_t'(owner_flit[FlitTypeMsb -: FlitTypeBits]);
  assign fwd        = (state_q == BUSY) && !bus.in_empty[owner_q] && !bus.out_full;
  assign owner_next = (owner_q == PtrW'(NumInputs - 1)) ? '0 : owner_q + 1'b1;

`ifdef ROUTER_ARB_WATCHDOG_EN
  localparam int CntW = $clog2(TimeoutCycles + 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Counts consecutive stalled BUSY cycles; any forwarded flit restarts it.
  assign timeout = (state_q == BUSY) && !fwd && (cnt_q == CntW'(TimeoutCycles - 1));

  always_comb begin
    cnt_d = cnt_q;
    if (state_q == IDLE || fwd || timeout) cnt_d = '0;
    else                                   cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) cnt_q <= '0;
    else      cnt_q <= cnt_d;
  end
`else
  assign timeout = 1'b0;
`endif

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    owner_d       = owner_q;
    ptr_d         = ptr_q;
    err_d         = err_q;
    first_d       = first_q;
    bus.in_rdreq  = '0;
    bus.out_valid = 1'b0;
    bus.out_data  = '0;
    case (state_q)
      IDLE: begin
        if (|bad_head) err_d = 1'b1;
        if (arb_valid) begin
          state_d = BUSY;
          grant_d = arb_gnt;
          owner_d = arb_idx;
          first_d = 1'b1;
        end
      end
      BUSY: begin
        if (fwd) begin
          bus.out_valid         = 1'b1;
          bus.out_data          = owner_flit;
          bus.in_rdreq[owner_q] = 1'b1;
          first_d               = 1'b0;
          // A fresh header inside an open packet is a protocol break.
          if (owner_type == HEAD && !first_q) err_d = 1'b1;
          if (is_last(owner_type)) begin
            state_d = IDLE;
            grant_d = '0;
            ptr_d   = owner_next;
          end
        end else if (timeout) begin
          err_d   = 1'b1;
          state_d = IDLE;
          grant_d = '0;
          ptr_d   = owner_next;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= IDLE;
      grant_q <= '0;
      owner_q <= '0;
      ptr_q   <= '0;
      err_q   <= 1'b0;
      first_q <= 1'b0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      owner_q <= owner_d;
      ptr_q   <= ptr_d;
      err_q   <= err_d;
      first_q <= first_d;
    end
  end

  assign bus.grant = grant_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_router_out_arbiter.sv
// Directed scoreboard bench for router_out_arbiter; FIFOs are modelled as
// simple arrays and expected flits are queued with their source input.
module tb_router_out_arbiter;

  localparam int N = 5;
  localparam int W = 8;

  typedef struct packed {
    logic [2:0]   src;
    logic [W-1:0] flit;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b0;

  router_out_if #(.NumInputs(N), .Width(W)) bus ();

  router_out_arbiter #(
    .NumInputs     (N),
    .Width         (W),
    .TimeoutCycles (8)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int           total = 0;
  int           bad   = 0;
  exp_t         sb[$];
  logic [W-1:0] mem [N][16];
  int           rd [N];
  int           wr [N];
  logic [N-1:0] grant_seen;
  int           ncyc;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic refresh();
    for (int i = 0; i < N; i++) begin
      bus.in_empty[i] = (rd[i] == wr[i]);
      bus.in_data[i]  = (rd[i] == wr[i]) ? '0 : mem[i][rd[i] % 16];
    end
  endtask

  task automatic push(input int i, input logic [W-1:0] f);
    mem[i][wr[i] % 16] = f;
    wr[i]++;
    refresh();
  endtask

  task automatic expect_flit(input int src, input logic [W-1:0] f);
    exp_t e;
    e.src  = 3'(src);
    e.flit = f;
    sb.push_back(e);
  endtask

  task automatic clear_fifos();
    for (int i = 0; i < N; i++) begin
      rd[i] = 0;
      wr[i] = 0;
    end
    refresh();
  endtask

  // One clock: check outputs just after the falling edge, pop model FIFOs
  // just after the rising edge, return at the next falling edge.
  task automatic cycle();
    logic [N-1:0] pops;
    exp_t         e;
    #1;
    grant_seen = grant_seen | bus.grant;
    if (bus.out_valid) begin
      total++;
      assert (sb.size() > 0) else begin
        bad++;
        $error("FAIL sb_underflow: observed out_data=%0h expected no flit", bus.out_data);
      end
      if (sb.size() > 0) begin
        e = sb.pop_front();
        chk("out_data", bus.out_data, e.flit);
        chk("out_src", bus.grant, 5'b00001 << e.src);
        chk("rdreq", bus.in_rdreq, 5'b00001 << e.src);
      end
    end else begin
      chk("idle_data", bus.out_data, 0);
      chk("idle_rdreq", bus.in_rdreq, 0);
    end
    pops = bus.in_rdreq;
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) if (pops[i]) rd[i]++;
    refresh();
    @(negedge clk);
  endtask

  task automatic drain(input string tag, input int max_cycles, output int n);
    n = 0;
    #1;
    while (!(sb.size() == 0 && bus.grant == '0 && !bus.out_valid) && n < max_cycles) begin
      cycle();
      n++;
      #1;
    end
    chk({tag, "_drained"}, (n < max_cycles), 1);
    chk({tag, "_sb_left"}, sb.size(), 0);
  endtask

  initial begin
    #50000;
    $display("[TB] FAIL global_timeout: observed no finish expected finish");
    $fatal(1, "[TB] simulation hung");
  end

  initial begin
    bus.out_full = 1'b0;
    grant_seen   = '0;
    clear_fifos();

    // Reset state
    repeat (2) @(negedge clk);
    #1;
    chk("rst_grant", bus.grant, 0);
    chk("rst_valid", bus.out_valid, 0);
    chk("rst_data", bus.out_data, 0);
    chk("rst_rdreq", bus.in_rdreq, 0);
    chk("rst_err", bus.err, 0);
    @(negedge clk);
    rst = 1'b1;

    // Single packet on input 0: one idle arbitration cycle, then 3 flits
    push(0, 8'h80); push(0, 8'h05); push(0, 8'h41);
    expect_flit(0, 8'h80); expect_flit(0, 8'h05); expect_flit(0, 8'h41);
    #1;
    chk("single_arb_valid", bus.out_valid, 0);
    chk("single_arb_grant", bus.grant, 0);
    drain("single", 20, ncyc);
    chk("single_cycles", ncyc, 4);
    chk("single_pops", rd[0], 3);
    chk("single_grant_end", bus.grant, 0);

    // Move rr pointer to 0 through input 4, then contention from rr=0
    clear_fifos();
    push(4, 8'hC4); expect_flit(4, 8'hC4);
    drain("ptr_to0", 10, ncyc);
    push(0, 8'hC0); push(2, 8'hC2); push(4, 8'hC4);
    expect_flit(0, 8'hC0); expect_flit(2, 8'hC2); expect_flit(4, 8'hC4);
    drain("cont_rr0", 20, ncyc);
    chk("cont_rr0_cycles", ncyc, 6);

    // Move rr pointer to 3 through input 2, then contention from rr=3
    push(2, 8'hC2); expect_flit(2, 8'hC2);
    drain("ptr_to3", 10, ncyc);
    push(0, 8'hC0); push(2, 8'hC2); push(4, 8'hC4);
    expect_flit(4, 8'hC4); expect_flit(0, 8'hC0); expect_flit(2, 8'hC2);
    drain("cont_rr3", 20, ncyc);
    chk("cont_rr3_cycles", ncyc, 6);

    // Wormhole hold: input 1 owns the link with an empty FIFO, input 3 waits
    clear_fifos();
    push(1, 8'h81); expect_flit(1, 8'h81);
    cycle(); cycle();
    push(3, 8'hC3);
    for (int k = 0; k < 10; k++) begin
      #1;
      chk("hold_grant", bus.grant, 5'b00010);
      chk("hold_rdreq3", bus.in_rdreq[3], 0);
      cycle();
    end
    push(1, 8'h11); push(1, 8'h51);
    expect_flit(1, 8'h11); expect_flit(1, 8'h51); expect_flit(3, 8'hC3);
    drain("hold", 20, ncyc);
    chk("hold_cycles", ncyc, 4);

    // Backpressure mid-packet (rr now 4, only input 0 competes)
    clear_fifos();
    push(0, 8'h80); push(0, 8'h06); push(0, 8'h07); push(0, 8'h48);
    expect_flit(0, 8'h80); expect_flit(0, 8'h06); expect_flit(0, 8'h07); expect_flit(0, 8'h48);
    cycle(); cycle(); cycle();
    bus.out_full = 1'b1;
    for (int k = 0; k < 4; k++) begin
      #1;
      chk("bp_grant", bus.grant, 5'b00001);
      chk("bp_valid", bus.out_valid, 0);
      cycle();
    end
    bus.out_full = 1'b0;
    drain("bp", 10, ncyc);
    chk("bp_cycles", ncyc, 2);

    // Protocol error: input 2 presents BODY in IDLE, input 3 a HEADTAIL
    clear_fifos();
    #1;
    chk("perr_before", bus.err, 0);
    grant_seen = '0;
    push(2, 8'h07); push(3, 8'hC3);
    expect_flit(3, 8'hC3);
    drain("perr", 10, ncyc);
    chk("perr_err", bus.err, 1);
    repeat (3) cycle();
    #1;
    chk("perr_sticky", bus.err, 1);
    chk("perr_no_grant2", grant_seen[2], 0);
    chk("perr_no_pop2", rd[2], 0);

    // Reset mid-packet: outputs return to reset values immediately
    clear_fifos();
    push(0, 8'h80); push(0, 8'h01); push(0, 8'h42);
    expect_flit(0, 8'h80);
    cycle(); cycle();
    #1;
    chk("mid_grant_pre", bus.grant, 5'b00001);
    rst = 1'b0;
    #1;
    chk("mid_rst_grant", bus.grant, 0);
    chk("mid_rst_valid", bus.out_valid, 0);
    chk("mid_rst_data", bus.out_data, 0);
    chk("mid_rst_rdreq", bus.in_rdreq, 0);
    chk("mid_rst_err", bus.err, 0);
    chk("mid_rst_sb", sb.size(), 0);
    clear_fifos();
    @(negedge clk);
    rst = 1'b1;

`ifdef ROUTER_ARB_WATCHDOG_EN
    // Watchdog: owner stalls after its header for 8 cycles
    push(1, 8'h81); expect_flit(1, 8'h81);
    cycle(); cycle();
    repeat (7) cycle();
    #1;
    chk("wd_grant_pre", bus.grant, 5'b00010);
    chk("wd_err_pre", bus.err, 0);
    cycle();
    #1;
    chk("wd_grant", bus.grant, 0);
    chk("wd_err", bus.err, 1);
    clear_fifos();
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
